// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select adder/subtractor (A+B or A-B) with valid/ready streams.
// Latency: STAGES = WIDTH/SLICE cycles from accept to out_valid; one beat per cycle.
// Backpressure: per-stage ready chain; a stalled stage holds its contents, STAGES beats of buffering.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          operand beat handshake (in_a, in_b, in_sub)
//   out_valid/out_ready        result beat handshake (out_sum, out_cout, out_ovf)
//   in_sub                     0: A+B, 1: A+~B+1
//   out_cout                   carry out of the MSB (for subtract: 1 = no borrow)
//   out_ovf                    signed overflow
module csa_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / SLICE;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("csa_addsub_pipe: WIDTH must be a multiple of SLICE");
  end

  // Stage k register holds result bits [(k+1)*SLICE-1:0] already resolved,
  // the operands (only bits above the resolved part still matter), and the
  // carry out of slice k.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] cy_d;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic              ovf_q;
  logic              ovf_d;

  // What each stage sees coming from upstream: the input port for stage 0,
  // the previous stage register otherwise.
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_res [STAGES];

  // rdy[k]: stage k may load this cycle (empty, or its content moves on).
  logic [STAGES:0] rdy;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}}) << (k * SLICE);

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE:0]   s0;
    logic [SLICE:0]   s1;
    logic [SLICE:0]   sel;
    logic [WIDTH-1:0] slice_w;

    assign rdy[k] = !vld_q[k] || rdy[k+1];

    if (k == 0) begin : g_head
      // Subtract is A + ~B + 1: invert B once on entry, inject the +1 as carry-in.
      assign src_vld[k] = in_valid;
      assign src_c[k]   = in_sub;
      assign src_a[k]   = in_a;
      assign src_b[k]   = in_sub ? ~in_b : in_b;
      assign src_res[k] = '0;
    end else begin : g_body
      assign src_vld[k] = vld_q[k-1];
      assign src_c[k]   = cy_q[k-1];
      assign src_a[k]   = a_q[k-1];
      assign src_b[k]   = b_q[k-1];
      assign src_res[k] = res_q[k-1];
    end

    // Both carry-in candidates, then the real carry picks one.
    assign sa  = src_a[k][k*SLICE +: SLICE];
    assign sb  = src_b[k][k*SLICE +: SLICE];
    assign s0  = {1'b0, sa} + {1'b0, sb};
    assign s1  = s0 + {{SLICE{1'b0}}, 1'b1};
    assign sel = src_c[k] ? s1 : s0;

    assign slice_w  = WIDTH'(sel[SLICE-1:0]) << (k * SLICE);
    assign res_d[k] = (src_res[k] & ~MASK) | slice_w;
    assign cy_d[k]  = sel[SLICE];

    if (k == STAGES - 1) begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit; overflow is
      // that carry disagreeing with the carry out.
      assign ovf_d = (sa[SLICE-1] ^ sb[SLICE-1] ^ sel[SLICE-1]) ^ sel[SLICE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q            <= '0;
      cy_q             <= '0;
      ovf_q            <= 1'b0;
      res_q[STAGES-1]  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) begin
            res_q[k] <= res_d[k];
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            cy_q[k]  <= cy_d[k];
          end
        end
      end
      if (rdy[STAGES-1] && src_vld[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = res_q[STAGES-1];
  assign out_cout  = cy_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule
